// File: rtl/if_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl_pkg
//   Shared types and constants for the instruction-fetch controller.
//   - if_state_e : fetch FSM state encoding (REQ / WAIT / HOLD)
//   - if_slot_t  : one instruction slot handed to ID {pc, inst, adef}
//   - RESET_PC_DEFAULT, PC_STEP : PC constants
//   - is_word_aligned() : PC alignment test on the low two address bits
// ---------------------------------------------------------------------------
package if_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    IF_ST_REQ  = 2'd0,
    IF_ST_WAIT = 2'd1,
    IF_ST_HOLD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } if_slot_t;

  function automatic logic is_word_aligned(input logic [1:0] pc_lo);
    return (pc_lo == 2'b00);
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// ---------------------------------------------------------------------------
// if_inst_buf
//   Single-entry holding register for the instruction slot offered to ID.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     load         : capture load_slot, mark valid
//     clear        : drop the held slot (takes priority over load)
//     load_slot    : {pc, inst, adef} to capture
//     slot_valid   : a slot is held
//     slot         : held {pc, inst, adef}; all-zero when empty after reset
// ---------------------------------------------------------------------------
module if_inst_buf
  import if_fetch_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     clear,
  input  if_slot_t load_slot,
  output logic     slot_valid,
  output if_slot_t slot
);

  logic     valid_reg;
  if_slot_t slot_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      slot_reg  <= '0;
    end else if (clear) begin
      // Contents zeroed so that an idle slot shows a quiet if_pc/if_inst.
      valid_reg <= 1'b0;
      slot_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      slot_reg  <= load_slot;
    end
  end

  assign slot_valid = valid_reg;
  assign slot       = slot_reg;

endmodule

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//   Instruction-fetch controller. Owns the architectural fetch PC, issues one
//   fetch at a time on an SRAM-like req/addr_ok/data_ok port, hands words to
//   ID over a valid/allowin handshake and applies ID redirects, discarding
//   wrong-path data even when it is still in flight.
//   Parameters:
//     RESET_PC     : PC of the first fetch after reset release
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     redirect     : jump taken from ID (single-cycle pulse)
//     redirect_pc  : target PC, used when redirect=1
//     inst_req     : fetch request valid
//     inst_addr    : fetch address (the PC register)
//     inst_addr_ok : request accepted this cycle
//     inst_data_ok : read data returns this cycle
//     inst_rdata   : instruction word, valid with inst_data_ok
//     id_allowin   : ID accepts an instruction this cycle
//     if_valid     : instruction offered to ID
//     if_pc        : PC of the offered instruction
//     if_inst      : offered instruction word
//     if_adef      : offered slot is a misaligned-PC fault (if_inst = 0)
// ---------------------------------------------------------------------------
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        id_allowin,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adef
);

  if_state_e   state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        cancel_reg, cancel_next;
  logic        req_reg, req_next;

  logic        buf_load, buf_clear, buf_valid;
  if_slot_t    buf_slot, load_slot;

  logic        req_fire;
  logic        pass_through;
  logic [31:0] pc_plus4;

  if_inst_buf u_inst_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_slot  (load_slot),
    .slot_valid (buf_valid),
    .slot       (buf_slot)
  );

  // inst_req comes from a register, so the handshake uses the registered
  // request and nothing on the memory side can reach inst_req/inst_addr.
  assign req_fire = req_reg & inst_addr_ok;

  // A returning word on a live (not cancelled) fetch is offered to ID in the
  // cycle it arrives, ahead of being captured in the buffer.
  assign pass_through = (state_reg == IF_ST_WAIT) & inst_data_ok & ~cancel_reg;
  assign pc_plus4     = pc_reg + PC_STEP;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    cancel_next = cancel_reg;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    load_slot   = '0;

    if (redirect) begin
      // Redirect overrides everything: new PC, any held slot dropped.
      pc_next     = redirect_pc;
      buf_clear   = 1'b1;
      state_next  = IF_ST_REQ;
      cancel_next = 1'b0;
      case (state_reg)
        IF_ST_REQ: begin
          // The request accepted this cycle is already in flight.
          if (req_fire) begin
            cancel_next = 1'b1;
            state_next  = IF_ST_WAIT;
          end
        end
        IF_ST_WAIT: begin
          // Wait out the outstanding word; if it arrives now, just drop it.
          if (!inst_data_ok) begin
            cancel_next = 1'b1;
            state_next  = IF_ST_WAIT;
          end
        end
        default: ;
      endcase
    end else begin
      case (state_reg)
        IF_ST_REQ: begin
          if (!is_word_aligned(pc_reg[1:0])) begin
            // No fetch for a misaligned PC; hand ID a fault slot instead.
            buf_load       = 1'b1;
            load_slot.pc   = pc_reg;
            load_slot.inst = 32'h0;
            load_slot.adef = 1'b1;
            state_next     = IF_ST_HOLD;
          end else if (req_fire) begin
            state_next = IF_ST_WAIT;
          end
        end
        IF_ST_WAIT: begin
          if (inst_data_ok) begin
            if (cancel_reg) begin
              cancel_next = 1'b0;
              state_next  = IF_ST_REQ;
            end else if (id_allowin) begin
              // Passed straight through to ID; nothing to hold.
              pc_next    = pc_plus4;
              state_next = IF_ST_REQ;
            end else begin
              buf_load       = 1'b1;
              load_slot.pc   = pc_reg;
              load_slot.inst = inst_rdata;
              load_slot.adef = 1'b0;
              state_next     = IF_ST_HOLD;
            end
          end
        end
        IF_ST_HOLD: begin
          if (id_allowin) begin
            buf_clear  = 1'b1;
            pc_next    = pc_plus4;
            state_next = IF_ST_REQ;
          end
        end
        default: state_next = IF_ST_REQ;
      endcase
    end

    req_next = (state_next == IF_ST_REQ) & is_word_aligned(pc_next[1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IF_ST_REQ;
      pc_reg     <= RESET_PC;
      cancel_reg <= 1'b0;
      req_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      cancel_reg <= cancel_next;
      req_reg    <= req_next;
    end
  end

  assign inst_req  = req_reg;
  assign inst_addr = pc_reg;

  // redirect masks the offer in the same cycle so a taken jump never lets a
  // wrong-path instruction into ID.
  assign if_valid = (((state_reg == IF_ST_HOLD) & buf_valid) | pass_through) & ~redirect;
  assign if_pc    = pass_through ? pc_reg     : buf_slot.pc;
  assign if_inst  = pass_through ? inst_rdata : buf_slot.inst;
  assign if_adef  = pass_through ? 1'b0       : buf_slot.adef;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
//   Directed bench for if_fetch_ctrl. Inputs change 1 time unit after the
//   rising edge; outputs are checked 1 unit later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_allowin;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adef;

  int tests_run;
  int tests_failed;

  if_fetch_ctrl #(.RESET_PC(32'h1c00_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_allowin   (id_allowin),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_adef      (if_adef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    id_allowin   = 1'b0;

    // ---- Reset values
    step(); step();
    chk1 ("rst_req",    inst_req,  1'b0);
    chk32("rst_addr",   inst_addr, 32'h1c00_0000);
    chk1 ("rst_valid",  if_valid,  1'b0);
    chk32("rst_if_pc",  if_pc,     32'h0);
    chk32("rst_if_inst",if_inst,   32'h0);
    chk1 ("rst_adef",   if_adef,   1'b0);
    $display("[TB] reset values checked");

    // ---- 1: zero-wait fetch after reset release
    rst_n = 1'b1;
    step();                                   // cyc1
    inst_addr_ok = 1'b1; id_allowin = 1'b1;
    #1;
    chk1 ("t1_req_c1",  inst_req,  1'b1);
    chk32("t1_addr_c1", inst_addr, 32'h1c00_0000);
    step();                                   // cyc2
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0280_0000;
    #1;
    chk1 ("t1_valid_c2", if_valid, 1'b1);
    chk32("t1_inst_c2",  if_inst,  32'h0280_0000);
    chk32("t1_pc_c2",    if_pc,    32'h1c00_0000);
    chk1 ("t1_noreq_c2", inst_req, 1'b0);
    step();                                   // cyc3
    inst_data_ok = 1'b0;
    #1;
    chk1 ("t1_req_c3",  inst_req,  1'b1);
    chk32("t1_addr_c3", inst_addr, 32'h1c00_0004);
    $display("[TB] test1 fetch: addr=%h valid=%b", inst_addr, if_valid);

    // ---- 2: ID stalls for 5 cycles with the slot held
    inst_addr_ok = 1'b1; id_allowin = 1'b0;
    step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_1111;
    #1;
    chk1("t2_pass_valid", if_valid, 1'b1);
    step();
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1 ("t2_hold_valid", if_valid,  1'b1);
      chk32("t2_hold_pc",    if_pc,     32'h1c00_0004);
      chk32("t2_hold_inst",  if_inst,   32'h1111_1111);
      chk1 ("t2_hold_noreq", inst_req,  1'b0);
      chk32("t2_hold_addr",  inst_addr, 32'h1c00_0004);
      step();
    end
    id_allowin = 1'b1;
    #1;
    chk1("t2_release_valid", if_valid, 1'b1);
    step();
    #1;
    chk32("t2_next_addr", inst_addr, 32'h1c00_0008);
    chk1 ("t2_next_req",  inst_req,  1'b1);
    $display("[TB] test2 stall: next addr=%h", inst_addr);

    // ---- 3: redirect while WAIT, stale word arrives 3 cycles later
    inst_addr_ok = 1'b1;
    step();                                   // WAIT on 1c000008
    inst_addr_ok = 1'b0; redirect = 1'b1; redirect_pc = 32'h1c00_0100;
    #1;
    chk1("t3_redir_valid", if_valid, 1'b0);
    step();
    redirect = 1'b0;
    #1;
    chk1 ("t3_cancel_noreq", inst_req,  1'b0);
    chk32("t3_cancel_addr",  inst_addr, 32'h1c00_0100);
    step();
    step();
    inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
    #1;
    chk1("t3_stale_valid", if_valid, 1'b0);
    step();
    inst_data_ok = 1'b0;
    #1;
    chk1 ("t3_after_valid", if_valid,  1'b0);
    chk1 ("t3_target_req",  inst_req,  1'b1);
    chk32("t3_target_addr", inst_addr, 32'h1c00_0100);
    $display("[TB] test3 redirect in WAIT: addr=%h", inst_addr);

    // ---- 4: redirect in the same cycle as data_ok
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2222_2222;
    redirect = 1'b1; redirect_pc = 32'h1c00_0200;
    #1;
    chk1("t4_masked_valid", if_valid, 1'b0);
    step();
    inst_data_ok = 1'b0; redirect = 1'b0;
    #1;
    chk1 ("t4_req",  inst_req,  1'b1);
    chk32("t4_addr", inst_addr, 32'h1c00_0200);
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3333_3333;
    #1;
    chk1 ("t4_nocancel_valid", if_valid, 1'b1);
    chk32("t4_nocancel_inst",  if_inst,  32'h3333_3333);
    chk32("t4_nocancel_pc",    if_pc,    32'h1c00_0200);
    step();
    inst_data_ok = 1'b0;
    #1;
    chk32("t4_next_addr", inst_addr, 32'h1c00_0204);
    $display("[TB] test4 redirect with data_ok: addr=%h", inst_addr);

    // ---- 5: redirect to a misaligned target -> adef slot
    redirect = 1'b1; redirect_pc = 32'h1c00_0102;
    step();
    redirect = 1'b0; id_allowin = 1'b0;
    #1;
    chk1 ("t5_noreq",   inst_req,  1'b0);
    chk32("t5_addr",    inst_addr, 32'h1c00_0102);
    chk1 ("t5_c1_valid",if_valid,  1'b0);
    step();
    #1;
    chk1 ("t5_valid",   if_valid,  1'b1);
    chk1 ("t5_adef",    if_adef,   1'b1);
    chk32("t5_pc",      if_pc,     32'h1c00_0102);
    chk32("t5_inst",    if_inst,   32'h0);
    chk1 ("t5_hold_noreq", inst_req, 1'b0);
    // redirect during HOLD with allowin: no handoff, pc = target not pc+4
    redirect = 1'b1; redirect_pc = 32'h1c00_0300; id_allowin = 1'b1;
    #1;
    chk1("t5_hold_redir_valid", if_valid, 1'b0);
    step();
    redirect = 1'b0;
    #1;
    chk32("t5_hold_redir_addr", inst_addr, 32'h1c00_0300);
    chk1 ("t5_hold_redir_req",  inst_req,  1'b1);
    chk1 ("t5_adef_cleared",    if_adef,   1'b0);
    $display("[TB] test5 misaligned: addr=%h", inst_addr);

    // ---- 6: reset while WAIT, late data_ok after release is ignored
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0; rst_n = 1'b0;
    #1;
    chk1 ("t6_rst_req",   inst_req,  1'b0);
    chk32("t6_rst_addr",  inst_addr, 32'h1c00_0000);
    chk1 ("t6_rst_valid", if_valid,  1'b0);
    step();
    rst_n = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h4444_4444;
    #1;
    chk1("t6_late_valid", if_valid, 1'b0);
    chk1("t6_late_noreq", inst_req, 1'b0);
    step();
    inst_data_ok = 1'b0;
    #1;
    chk1 ("t6_after_valid", if_valid,  1'b0);
    chk1 ("t6_first_req",   inst_req,  1'b1);
    chk32("t6_first_addr",  inst_addr, 32'h1c00_0000);
    $display("[TB] test6 reset mid-fetch: addr=%h", inst_addr);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
